// File: rtl/rot_ctrl.sv
// Rotate-core sequencer: walks the source image in raster order and, per pixel,
// issues one DMA read and one DMA write to the rotated destination address.
module rot_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              I_ROTCTRL_PCLK,
    input  logic              I_ROTCTRL_PRESET_N,
    input  logic              I_ROTCTRL_START,
    input  logic              I_ROTCTRL_SRESET,
    input  logic [ADDR_W-1:0] I_ROTCTRL_SRC,
    input  logic [ADDR_W-1:0] I_ROTCTRL_DST,
    input  logic [DIM_W-1:0]  I_ROTCTRL_H,
    input  logic [DIM_W-1:0]  I_ROTCTRL_W,
    input  logic [1:0]        I_ROTCTRL_MODE,
    input  logic              I_ROTCTRL_DIR,
    input  logic              I_ROTCTRL_INTR_MASK,
    input  logic              I_ROTCTRL_INTR_CLR,
    output logic              O_ROTCTRL_RD_REQ,
    output logic [ADDR_W-1:0] O_ROTCTRL_RD_ADDR,
    input  logic              I_ROTCTRL_RD_ACK,
    input  logic [DATA_W-1:0] I_ROTCTRL_RD_DATA,
    output logic              O_ROTCTRL_WR_REQ,
    output logic [ADDR_W-1:0] O_ROTCTRL_WR_ADDR,
    output logic [DATA_W-1:0] O_ROTCTRL_WR_DATA,
    input  logic              I_ROTCTRL_WR_ACK,
    output logic [DIM_W-1:0]  O_ROTCTRL_NEW_H,
    output logic [DIM_W-1:0]  O_ROTCTRL_NEW_W,
    output logic              O_ROTCTRL_START_CLR,
    output logic              O_ROTCTRL_BUSY,
    output logic              O_ROTCTRL_IRQ
);

    localparam int PW = (ADDR_W > 2 * DIM_W) ? ADDR_W : 2 * DIM_W;
    localparam logic [DIM_W-1:0] ONE_D = 1;
    localparam logic [PW-1:0]    ONE_P = 1;

    // RD_END / WR_END are the one-cycle request-drop slots after each ack.
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_RD, S_RD_END, S_WR, S_WR_END, S_NEXT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              start_d_q;
    logic [DIM_W-1:0]  r_q, r_d, c_q, c_d;
    logic              pending_q, pending_d;
    logic [DIM_W-1:0]  new_h_q, new_w_q;

    logic [ADDR_W-1:0] src_q, dst_q;
    logic [DIM_W-1:0]  h_q, w_q;
    logic [1:0]        rot_q;
    logic [DATA_W-1:0] pix_q;

    logic              launch;
    logic [1:0]        eff_rot;
    logic [PW-1:0]     rr, cc, hh, ww, lin, idx;

    assign launch  = (state_q == S_IDLE) && I_ROTCTRL_START && !start_d_q && !I_ROTCTRL_SRESET;
    // CCW swaps the two quarter turns; 0 and 180 are direction-independent.
    assign eff_rot = I_ROTCTRL_MODE ^ {I_ROTCTRL_DIR & I_ROTCTRL_MODE[0], 1'b0};

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        pending_d = pending_q;
        if (I_ROTCTRL_INTR_CLR) pending_d = 1'b0;
        if (state_q == S_DONE)  pending_d = 1'b1;
        case (state_q)
            S_IDLE:   if (launch) state_d = S_SETUP;
            S_SETUP: begin
                r_d = '0;
                c_d = '0;
                state_d = (h_q == '0 || w_q == '0) ? S_DONE : S_RD;
            end
            S_RD:     if (I_ROTCTRL_RD_ACK) state_d = S_RD_END;
            S_RD_END: state_d = S_WR;
            S_WR:     if (I_ROTCTRL_WR_ACK) state_d = S_WR_END;
            S_WR_END: state_d = S_NEXT;
            S_NEXT: begin
                if (c_q == w_q - ONE_D) begin
                    c_d = '0;
                    if (r_q == h_q - ONE_D) begin
                        state_d = S_DONE;
                    end else begin
                        r_d = r_q + ONE_D;
                        state_d = S_RD;
                    end
                end else begin
                    c_d = c_q + ONE_D;
                    state_d = S_RD;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (I_ROTCTRL_SRESET) begin
            state_d = S_IDLE;
            r_d = '0;
            c_d = '0;
        end
    end

    always_ff @(posedge I_ROTCTRL_PCLK) begin
        if (!I_ROTCTRL_PRESET_N) begin
            state_q   <= S_IDLE;
            start_d_q <= 1'b0;
            r_q       <= '0;
            c_q       <= '0;
            pending_q <= 1'b0;
            new_h_q   <= '0;
            new_w_q   <= '0;
        end else begin
            state_q   <= state_d;
            start_d_q <= I_ROTCTRL_START;
            r_q       <= r_d;
            c_q       <= c_d;
            pending_q <= pending_d;
            if (state_q == S_SETUP && !I_ROTCTRL_SRESET) begin
                new_h_q <= rot_q[0] ? w_q : h_q;
                new_w_q <= rot_q[0] ? h_q : w_q;
            end
        end
    end

    // Job configuration and pixel buffer; outputs are gated so these need no reset.
    always_ff @(posedge I_ROTCTRL_PCLK) begin
        if (launch) begin
            src_q <= I_ROTCTRL_SRC;
            dst_q <= I_ROTCTRL_DST;
            h_q   <= I_ROTCTRL_H;
            w_q   <= I_ROTCTRL_W;
            rot_q <= eff_rot;
        end
        if (state_q == S_RD && I_ROTCTRL_RD_ACK) pix_q <= I_ROTCTRL_RD_DATA;
    end

    always_comb begin
        rr  = PW'(r_q);
        cc  = PW'(c_q);
        hh  = PW'(h_q);
        ww  = PW'(w_q);
        lin = rr * ww + cc;
        case (rot_q)
            2'd1:    idx = cc * hh + (hh - ONE_P - rr);
            2'd2:    idx = (hh - ONE_P - rr) * ww + (ww - ONE_P - cc);
            2'd3:    idx = (ww - ONE_P - cc) * hh + rr;
            default: idx = lin;
        endcase
    end

    assign O_ROTCTRL_RD_REQ    = (state_q == S_RD);
    assign O_ROTCTRL_WR_REQ    = (state_q == S_WR);
    assign O_ROTCTRL_RD_ADDR   = O_ROTCTRL_RD_REQ ? src_q + lin[ADDR_W-1:0] : '0;
    assign O_ROTCTRL_WR_ADDR   = O_ROTCTRL_WR_REQ ? dst_q + idx[ADDR_W-1:0] : '0;
    assign O_ROTCTRL_WR_DATA   = O_ROTCTRL_WR_REQ ? pix_q : '0;
    assign O_ROTCTRL_NEW_H     = new_h_q;
    assign O_ROTCTRL_NEW_W     = new_w_q;
    assign O_ROTCTRL_START_CLR = (state_q == S_SETUP);
    assign O_ROTCTRL_BUSY      = (state_q != S_IDLE);
    assign O_ROTCTRL_IRQ       = pending_q & ~I_ROTCTRL_INTR_MASK;

endmodule

// File: tb/tb_rot_ctrl.sv
// Directed bench for rot_ctrl: a DMA responder with programmable ack latency,
// a negedge monitor logging writes/handshake rules, and hand-computed expectations.
module tb_rot_ctrl;

    logic        pclk = 1'b0;
    logic        preset_n, start, sreset, mask, intr_clr, dir;
    logic [31:0] src, dst;
    logic [15:0] h, w;
    logic [1:0]  mode;
    logic        rd_req, wr_req, rd_ack, wr_ack, start_clr, busy, irq;
    logic [31:0] rd_addr, wr_addr;
    logic [7:0]  rd_data, wr_data;
    logic [15:0] new_h, new_w;

    logic        ack_en, wr_force;
    int          rd_delay, wr_delay;
    int          rd_cnt = 0, wr_cnt = 0;

    int          checks = 0, failures = 0;
    int          n_clr = 0, n_busy = 0, n_req = 0, n_viol = 0;
    logic [31:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic        p_rd = 1'b0, p_wr = 1'b0, p_rd_ack = 1'b0, p_wr_ack = 1'b0, p_live = 1'b0;
    logic [31:0] p_rd_addr = '0, p_wr_addr = '0;
    logic [7:0]  p_wr_data = '0;

    always #5 pclk = ~pclk;

    rot_ctrl dut (
        .I_ROTCTRL_PCLK(pclk), .I_ROTCTRL_PRESET_N(preset_n),
        .I_ROTCTRL_START(start), .I_ROTCTRL_SRESET(sreset),
        .I_ROTCTRL_SRC(src), .I_ROTCTRL_DST(dst), .I_ROTCTRL_H(h), .I_ROTCTRL_W(w),
        .I_ROTCTRL_MODE(mode), .I_ROTCTRL_DIR(dir),
        .I_ROTCTRL_INTR_MASK(mask), .I_ROTCTRL_INTR_CLR(intr_clr),
        .O_ROTCTRL_RD_REQ(rd_req), .O_ROTCTRL_RD_ADDR(rd_addr),
        .I_ROTCTRL_RD_ACK(rd_ack), .I_ROTCTRL_RD_DATA(rd_data),
        .O_ROTCTRL_WR_REQ(wr_req), .O_ROTCTRL_WR_ADDR(wr_addr),
        .O_ROTCTRL_WR_DATA(wr_data), .I_ROTCTRL_WR_ACK(wr_ack),
        .O_ROTCTRL_NEW_H(new_h), .O_ROTCTRL_NEW_W(new_w),
        .O_ROTCTRL_START_CLR(start_clr), .O_ROTCTRL_BUSY(busy), .O_ROTCTRL_IRQ(irq)
    );

    // DMA responder: ack once the request has waited the programmed number of cycles.
    always @(posedge pclk) begin
        rd_cnt <= rd_req ? rd_cnt + 1 : 0;
        wr_cnt <= wr_req ? wr_cnt + 1 : 0;
    end
    assign rd_ack  = ack_en && rd_req && (rd_cnt >= rd_delay);
    assign wr_ack  = (ack_en && wr_req && (wr_cnt >= wr_delay)) || wr_force;
    assign rd_data = rd_addr[7:0] ^ 8'h5A;

    always @(negedge pclk) begin
        if (wr_req && wr_ack) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (start_clr) n_clr++;
        if (busy) n_busy++;
        if (rd_req || wr_req) n_req++;
        if (rd_req && wr_req) n_viol++;
        if (p_live && p_rd && !p_rd_ack && (!rd_req || rd_addr != p_rd_addr)) n_viol++;
        if (p_live && p_wr && !p_wr_ack &&
            (!wr_req || wr_addr != p_wr_addr || wr_data != p_wr_data)) n_viol++;
        p_rd = rd_req;  p_rd_ack = rd_ack;  p_rd_addr = rd_addr;
        p_wr = wr_req;  p_wr_ack = wr_ack;  p_wr_addr = wr_addr;  p_wr_data = wr_data;
        p_live = preset_n && !sreset;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic start_job(input logic [15:0] jh, input logic [15:0] jw,
                             input logic [1:0] jm, input logic jd);
        h = jh; w = jw; mode = jm; dir = jd;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 600 && busy; i++) cyc(1);
        if (busy) check({tag, "_timeout"}, 64'(busy), 64'(0));
    endtask

    task automatic check_writes(input string tag, input int base, input int e[6]);
        check({tag, "_nwr"}, 64'(wa_q.size() - base), 64'(6));
        if (wa_q.size() - base == 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("%s_addr%0d", tag, k), 64'(wa_q[base+k]), 64'(32'h200 + 32'(e[k])));
                check($sformatf("%s_data%0d", tag, k), 64'(wd_q[base+k]), 64'(8'(k) ^ 8'h5A));
            end
        end
    endtask

    int exp0[6]   = '{0, 1, 2, 3, 4, 5};
    int exp90[6]  = '{1, 3, 5, 0, 2, 4};
    int exp270[6] = '{4, 2, 0, 5, 3, 1};
    int exp180[6] = '{5, 4, 3, 2, 1, 0};

    initial begin
        int base, clr0, busy0, req0, i;
        preset_n = 1'b0; start = 1'b0; sreset = 1'b0; mask = 1'b0; intr_clr = 1'b0;
        src = 32'h100; dst = 32'h200; h = 16'd2; w = 16'd3; mode = 2'd0; dir = 1'b0;
        ack_en = 1'b1; wr_force = 1'b0; rd_delay = 0; wr_delay = 0;
        cyc(3);
        @(negedge pclk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_req", 64'({rd_req, wr_req, start_clr, irq}), 64'(0));
        check("rst_new", 64'({new_h, new_w}), 64'(0));
        preset_n = 1'b1;
        cyc(1);

        // Hard reset while a read is outstanding
        ack_en = 1'b0;
        start_job(2, 3, 0, 0);
        cyc(1);
        check("mid_rdreq", 64'(rd_req), 64'(1));
        check("mid_rdaddr", 64'(rd_addr), 64'(32'h100));
        preset_n = 1'b0;
        cyc(1);
        check("mid_rst_out", 64'({rd_req, wr_req, busy, irq, start_clr}), 64'(0));
        check("mid_rst_new", 64'({new_h, new_w, rd_addr}), 64'(0));
        preset_n = 1'b1; ack_en = 1'b1;
        cyc(1);

        // 0 degrees, same-cycle acks: also measures the 5-cycle/pixel cadence
        base = wa_q.size(); clr0 = n_clr; busy0 = n_busy;
        start_job(2, 3, 0, 0);
        wait_idle("m0");
        check_writes("m0", base, exp0);
        check("m0_new", 64'({new_h, new_w}), 64'({16'd2, 16'd3}));
        check("m0_busy_cyc", 64'(n_busy - busy0), 64'(32));
        check("m0_startclr", 64'(n_clr - clr0), 64'(1));
        check("m0_irq", 64'(irq), 64'(1));
        intr_clr = 1'b1; cyc(1); intr_clr = 1'b0;
        check("m0_irq_clr", 64'(irq), 64'(0));

        base = wa_q.size();
        start_job(2, 3, 1, 0);
        wait_idle("m90");
        check_writes("m90", base, exp90);
        check("m90_new", 64'({new_h, new_w}), 64'({16'd3, 16'd2}));

        base = wa_q.size();
        start_job(2, 3, 1, 1);
        wait_idle("m90ccw");
        check_writes("m90ccw", base, exp270);

        base = wa_q.size();
        start_job(2, 3, 2, 1);
        wait_idle("m180");
        check_writes("m180", base, exp180);
        check("m180_new", 64'({new_h, new_w}), 64'({16'd2, 16'd3}));

        base = wa_q.size();
        start_job(2, 3, 3, 1);
        wait_idle("m270ccw");
        check_writes("m270ccw", base, exp90);
        check("m270ccw_new", 64'({new_h, new_w}), 64'({16'd3, 16'd2}));
        intr_clr = 1'b1; cyc(1); intr_clr = 1'b0;

        // Slow reads with START re-toggled mid-job
        rd_delay = 4;
        base = wa_q.size(); clr0 = n_clr; busy0 = n_busy;
        start_job(2, 3, 0, 0);
        cyc(9);
        start = 1'b1; cyc(1); start = 1'b0;
        wait_idle("slow");
        check_writes("slow", base, exp0);
        check("slow_startclr", 64'(n_clr - clr0), 64'(1));
        check("slow_busy_cyc", 64'(n_busy - busy0), 64'(56));
        cyc(3);
        check("slow_no_relaunch", 64'(busy), 64'(0));
        rd_delay = 0;
        intr_clr = 1'b1; cyc(1); intr_clr = 1'b0;

        // Empty image with interrupt masked, then mask/clear interplay
        mask = 1'b1; req0 = n_req;
        start_job(0, 3, 0, 0);
        check("h0_setup", 64'({busy, start_clr}), 64'(2'b11));
        cyc(1);
        check("h0_done", 64'(busy), 64'(1));
        cyc(1);
        check("h0_idle", 64'(busy), 64'(0));
        check("h0_irq_masked", 64'(irq), 64'(0));
        check("h0_noreq", 64'(n_req - req0), 64'(0));
        mask = 1'b0; #1;
        check("h0_irq_unmask", 64'(irq), 64'(1));
        intr_clr = 1'b1; cyc(1); intr_clr = 1'b0;
        check("h0_irq_clr", 64'(irq), 64'(0));
        start_job(0, 3, 0, 0);
        cyc(1);
        intr_clr = 1'b1; cyc(1); intr_clr = 1'b0;
        check("setclr_irq", 64'(irq), 64'(1));
        intr_clr = 1'b1; cyc(1); intr_clr = 1'b0;

        // Soft abort while a write waits for its ack
        wr_delay = 10;
        base = wa_q.size(); clr0 = n_clr;
        start_job(2, 3, 0, 0);
        for (i = 0; i < 50 && !wr_req; i++) cyc(1);
        check("sr_wrreq", 64'(wr_req), 64'(1));
        sreset = 1'b1;
        cyc(1);
        check("sr_drop", 64'({wr_req, rd_req, busy}), 64'(0));
        start = 1'b1;
        cyc(1);
        sreset = 1'b0; start = 1'b0; wr_force = 1'b1;
        cyc(1);
        wr_force = 1'b0;
        cyc(3);
        check("sr_idle", 64'({busy, wr_req, irq}), 64'(0));
        check("sr_new_kept", 64'({new_h, new_w}), 64'({16'd2, 16'd3}));
        check("sr_nwr", 64'(wa_q.size() - base), 64'(0));
        check("sr_startclr", 64'(n_clr - clr0), 64'(1));

        check("handshake_rules", 64'(n_viol), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
